// File: rtl/am_argmax_stream.sv
// ---------------------------------------------------------------------------
// am_argmax_stream
//   Streaming argmax over per-class similarity scores. LANES scores arrive per
//   beat. A running best and second-best are kept across the BEATS beats of one
//   inference, and the result is then held on a valid/ready output.
//
// Ports
//   clk         clock, rising edge
//   nrst        asynchronous active-low reset
//   abort       synchronous clear of an in-progress inference / held result
//   in_valid    input beat valid
//   in_ready    block can accept a beat (low only while a result is held)
//   in_sim      LANES packed scores; lane k is class beat*LANES+k
//   out_valid   result valid (HOLD)
//   out_ready   downstream accepts the result
//   out_class   index of the maximum score (lower index wins ties)
//   out_max     maximum score
//   out_second  second-highest score (a duplicate of the max counts)
//   out_margin  out_max - out_second
//   busy        inference in progress or result held
// ---------------------------------------------------------------------------
module am_argmax_stream #(
    parameter int  NUM_CLASSES = 26,
    parameter int  SIM_W       = 13,
    parameter int  LANES       = 4,
    localparam int CLS_W       = $clog2(NUM_CLASSES),
    localparam int BEATS       = (NUM_CLASSES + LANES - 1) / LANES
) (
    input  logic                   clk,
    input  logic                   nrst,
    input  logic                   abort,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [LANES*SIM_W-1:0] in_sim,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [CLS_W-1:0]       out_class,
    output logic [SIM_W-1:0]       out_max,
    output logic [SIM_W-1:0]       out_second,
    output logic [SIM_W-1:0]       out_margin,
    output logic                   busy
);

    localparam int BCNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t              state_reg, state_next;
    logic [BCNT_W-1:0]   beat_cnt_reg, beat_cnt_next;
    logic [SIM_W-1:0]    best_reg, best_next;
    logic [SIM_W-1:0]    second_reg, second_next;
    logic [CLS_W-1:0]    best_idx_reg, best_idx_next;
    logic [CLS_W-1:0]    out_class_reg, out_class_next;
    logic [SIM_W-1:0]    out_max_reg, out_max_next;
    logic [SIM_W-1:0]    out_second_reg, out_second_next;
    logic [SIM_W-1:0]    out_margin_reg, out_margin_next;

    // Lane unpacking and padding mask for the beat currently presented.
    logic [SIM_W-1:0]    lane_sim [LANES];
    logic [LANES-1:0]    lane_ok;
    int                  beat_base;

    assign beat_base = int'(beat_cnt_reg) * LANES;

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            assign lane_sim[gi] = in_sim[gi*SIM_W +: SIM_W];
            // Lanes past the last class on the final beat never participate.
            assign lane_ok[gi]  = (beat_base + gi) < NUM_CLASSES;
        end
    endgenerate

    // Top-2 over the lanes of one beat. Strict '>' keeps the lower lane as the
    // winner on a tie, while the tying lane still becomes second.
    logic [SIM_W-1:0]    lane_best, lane_second;
    int                  lane_best_lane;

    always_comb begin
        lane_best      = '0;
        lane_second    = '0;
        lane_best_lane = 0;
        for (int k = 0; k < LANES; k++) begin
            if (lane_ok[k]) begin
                if (k == 0 || lane_sim[k] > lane_best) begin
                    lane_second    = lane_best;
                    lane_best      = lane_sim[k];
                    lane_best_lane = k;
                end else if (lane_sim[k] > lane_second) begin
                    lane_second = lane_sim[k];
                end
            end
        end
    end

    // Merge the beat result with the running pair. In IDLE the running pair is
    // stale and is replaced by the beat alone.
    logic [SIM_W-1:0]    m_best, m_second;
    logic [CLS_W-1:0]    m_idx;
    logic [CLS_W-1:0]    lane_cls;

    assign lane_cls = CLS_W'(beat_base + lane_best_lane);

    always_comb begin
        m_best   = best_reg;
        m_second = second_reg;
        m_idx    = best_idx_reg;
        if (state_reg == IDLE) begin
            m_best   = lane_best;
            m_second = lane_second;
            m_idx    = lane_cls;
        end else if (lane_best > best_reg) begin
            m_best   = lane_best;
            m_idx    = lane_cls;
            m_second = (best_reg > lane_second) ? best_reg : lane_second;
        end else begin
            // Equal best keeps the earlier (lower) class; the incoming max
            // then becomes second, giving margin 0.
            m_second = (lane_best > second_reg) ? lane_best : second_reg;
        end
    end

    logic accept;
    logic last_beat;

    assign accept    = in_valid && in_ready;
    assign last_beat = (beat_cnt_reg == BCNT_W'(BEATS - 1));

    always_comb begin
        state_next      = state_reg;
        beat_cnt_next   = beat_cnt_reg;
        best_next       = best_reg;
        second_next     = second_reg;
        best_idx_next   = best_idx_reg;
        out_class_next  = out_class_reg;
        out_max_next    = out_max_reg;
        out_second_next = out_second_reg;
        out_margin_next = out_margin_reg;

        unique case (state_reg)
            IDLE, ACCUM: begin
                if (abort) begin
                    // In IDLE this simply discards a coincident beat.
                    state_next    = IDLE;
                    beat_cnt_next = '0;
                    best_next     = '0;
                    second_next   = '0;
                    best_idx_next = '0;
                end else if (accept) begin
                    best_next     = m_best;
                    second_next   = m_second;
                    best_idx_next = m_idx;
                    if (last_beat) begin
                        state_next      = HOLD;
                        beat_cnt_next   = '0;
                        out_class_next  = m_idx;
                        out_max_next    = m_best;
                        out_second_next = m_second;
                        out_margin_next = m_best - m_second;
                    end else begin
                        state_next    = ACCUM;
                        beat_cnt_next = beat_cnt_reg + BCNT_W'(1);
                    end
                end
            end
            HOLD: begin
                if (abort || out_ready) begin
                    state_next    = IDLE;
                    beat_cnt_next = '0;
                end
            end
            default: begin
                state_next    = IDLE;
                beat_cnt_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_reg      <= IDLE;
            beat_cnt_reg   <= '0;
            best_reg       <= '0;
            second_reg     <= '0;
            best_idx_reg   <= '0;
            out_class_reg  <= '0;
            out_max_reg    <= '0;
            out_second_reg <= '0;
            out_margin_reg <= '0;
        end else begin
            state_reg      <= state_next;
            beat_cnt_reg   <= beat_cnt_next;
            best_reg       <= best_next;
            second_reg     <= second_next;
            best_idx_reg   <= best_idx_next;
            out_class_reg  <= out_class_next;
            out_max_reg    <= out_max_next;
            out_second_reg <= out_second_next;
            out_margin_reg <= out_margin_next;
        end
    end

    // Result fields are zeroed while no result is held, so a dropped or
    // consumed result never lingers on the output bus.
    assign in_ready   = (state_reg != HOLD);
    assign out_valid  = (state_reg == HOLD);
    assign busy       = (state_reg != IDLE);
    assign out_class  = (state_reg == HOLD) ? out_class_reg  : '0;
    assign out_max    = (state_reg == HOLD) ? out_max_reg    : '0;
    assign out_second = (state_reg == HOLD) ? out_second_reg : '0;
    assign out_margin = (state_reg == HOLD) ? out_margin_reg : '0;

endmodule
